// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for the VGA output path. The system clock is
// divided down to the pixel rate, and the horizontal and vertical pixel
// counters advance on each pixel strobe. The counters, blank and the
// connector sync pins are all registered and change on the same edge, so the
// drawing blocks and the connector see the same position with no skew.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset; restarts the raster at (0,0)
//   hCount      current pixel column, 0..H_TOTAL-1
//   vCount      current line, 0..V_TOTAL-1
//   blank       high while (hCount, vCount) is outside the visible area
//   hsync       horizontal sync, at level HSYNC_POL while active
//   vsync       vertical sync, at level VSYNC_POL while active
//   pixel_en    one-clk strobe; the counters advance at the edge ending it
//   frame_start one-clk pulse in the first cycle after a wrap to (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] hCount,
  output logic [10:0] vCount,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        pixel_en,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [10:0] H_MAX    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [10:0]      h_count_q, h_count_d;
  logic [10:0]      v_count_q, v_count_d;
  logic             blank_q, blank_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;

  logic             pix_strobe;
  logic             h_wrap;
  logic             v_wrap;

  // Decoded straight from the divider register: with CLK_DIV=1 the divider
  // sits at 0 == DIV_MAX, so the strobe is permanently high, even in reset.
  assign pix_strobe = (div_cnt_q == DIV_MAX);
  assign h_wrap     = pix_strobe && (h_count_q == H_MAX);
  assign v_wrap     = h_wrap && (v_count_q == V_MAX);

  always_comb begin
    div_cnt_d     = div_cnt_q;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    blank_d       = blank_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;

    if (div_cnt_q == DIV_MAX) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    if (pix_strobe) begin
      h_count_d = h_wrap ? '0 : h_count_q + 11'd1;
    end

    if (h_wrap) begin
      v_count_d = v_wrap ? '0 : v_count_q + 11'd1;
    end

    // Decoded from the next counter values so the registered flags line up
    // with the registered counters in the same cycle.
    blank_d = (h_count_d >= H_VIS) || (v_count_d >= V_VIS);

    if ((h_count_d >= HS_START) && (h_count_d <= HS_END)) begin
      hsync_d = HSYNC_POL;
    end else begin
      hsync_d = ~HSYNC_POL;
    end

    if ((v_count_d >= VS_START) && (v_count_d <= VS_END)) begin
      vsync_d = VSYNC_POL;
    end else begin
      vsync_d = ~VSYNC_POL;
    end

    // Only a genuine wrap raises this, so leaving reset at (0,0) never does.
    frame_start_d = v_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q     <= '0;
      h_count_q     <= '0;
      v_count_q     <= '0;
      blank_q       <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hCount      = h_count_q;
  assign vCount      = v_count_q;
  assign blank       = blank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pixel_en    = pix_strobe;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Two instances share clock and reset:
//   dut 0: CLK_DIV=4, default horizontal timing, short 8-line frame, active-low syncs
//   dut 1: CLK_DIV=1, default horizontal timing, short 8-line frame, active-high syncs
// Expected outputs are hand-computed vectors keyed by cycle since reset
// release, plus expected pulse widths / frame intervals measured by the monitor.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [10:0] h_a, v_a, h_b, v_b;
  logic        b_a, hs_a, vs_a, pen_a, fs_a;
  logic        b_b, hs_b, vs_b, pen_b, fs_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .reset(rst), .hCount(h_a), .vCount(v_a), .blank(b_a),
    .hsync(hs_a), .vsync(vs_a), .pixel_en(pen_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(rst), .hCount(h_b), .vCount(v_b), .blank(b_b),
    .hsync(hs_b), .vsync(vs_b), .pixel_en(pen_b), .frame_start(fs_b)
  );

  typedef struct {
    int unsigned cyc;
    bit          in_rst;
    int          dut;
    int          id;
    logic [26:0] exp;   // {h, v, blank, hsync, vsync, pixel_en, frame_start}
  } vec_t;

  typedef struct {
    int          dut;
    int          kind;  // 0 hsync width, 1 vsync width, 2 frame_start width, 3 frame_start interval
    int unsigned val;
  } meas_t;

  vec_t        vq[$];
  meas_t       mq[$];
  int          vid = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;

  int unsigned pw_cnt[2][3];
  bit          pw_in[2][3];
  bit          fs_prev[2];
  int unsigned last_rise[2];

  function automatic logic [26:0] obs(input int d);
    if (d == 0) return {h_a, v_a, b_a, hs_a, vs_a, pen_a, fs_a};
    return {h_b, v_b, b_b, hs_b, vs_b, pen_b, fs_b};
  endfunction

  function automatic bit sig_active(input int d, input int k);
    case (k)
      0:       return (d == 0) ? !hs_a : hs_b;
      1:       return (d == 0) ? !vs_a : vs_b;
      default: return (d == 0) ? fs_a : fs_b;
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      0:       return "hsync_width";
      1:       return "vsync_width";
      2:       return "frame_start_width";
      default: return "frame_interval";
    endcase
  endfunction

  task automatic pv(input bit r, input int unsigned c, input int d, input int h, input int v,
                    input bit b, input bit hs, input bit vs, input bit pen, input bit fs);
    vec_t e;
    e.cyc    = c;
    e.in_rst = r;
    e.dut    = d;
    e.id     = vid;
    e.exp    = {11'(h), 11'(v), b, hs, vs, pen, fs};
    vid++;
    vq.push_back(e);
  endtask

  task automatic pm(input int d, input int k, input int unsigned val);
    meas_t m;
    m.dut  = d;
    m.kind = k;
    m.val  = val;
    mq.push_back(m);
  endtask

  task automatic cmp_vec(input vec_t e, input int unsigned c);
    logic [26:0] a;
    a = obs(e.dut);
    n_vec++;
    if (a !== e.exp || (!e.in_rst && e.cyc != c)) begin
      n_bad++;
      $display("FAIL vec%0d dut%0d rst=%0b cyc=%0d: got h=%0d v=%0d blank=%b hs=%b vs=%b pen=%b fs=%b; want cyc=%0d h=%0d v=%0d blank=%b hs=%b vs=%b pen=%b fs=%b",
               e.id, e.dut, e.in_rst, c, a[26:16], a[15:5], a[4], a[3], a[2], a[1], a[0],
               e.cyc, e.exp[26:16], e.exp[15:5], e.exp[4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
    end
  endtask

  task automatic report_meas(input int d, input int k, input int unsigned val);
    int idx;
    idx = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (idx < 0 && mq[i].dut == d && mq[i].kind == k) idx = i;
    end
    if (idx >= 0) begin
      n_vec++;
      if (val != mq[idx].val) begin
        n_bad++;
        $display("FAIL %s dut%0d: got %0d clks, want %0d clks", kname(k), d, val, mq[idx].val);
      end
      mq.delete(idx);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops due vectors, measures pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
          for (int k = 0; k < 3; k++) begin
            pw_cnt[d][k] = 0;
            pw_in[d][k]  = 1'b0;
          end
          fs_prev[d]   = 1'b0;
          last_rise[d] = 0;
        end
        while (vq.size() > 0 && vq[0].in_rst) begin
          cmp_vec(vq[0], cyc);
          void'(vq.pop_front());
        end
      end else begin
        while (vq.size() > 0 && !vq[0].in_rst && vq[0].cyc <= cyc) begin
          cmp_vec(vq[0], cyc);
          void'(vq.pop_front());
        end
        for (int d = 0; d < 2; d++) begin
          for (int k = 0; k < 3; k++) begin
            if (sig_active(d, k)) begin
              pw_cnt[d][k]++;
              pw_in[d][k] = 1'b1;
            end else if (pw_in[d][k]) begin
              report_meas(d, k, pw_cnt[d][k]);
              pw_in[d][k]  = 1'b0;
              pw_cnt[d][k] = 0;
            end
          end
          if (sig_active(d, 2) && !fs_prev[d]) begin
            report_meas(d, 3, cyc - last_rise[d]);
            last_rise[d] = cyc;
          end
          fs_prev[d] = sig_active(d, 2);
        end
        cyc++;
      end
    end
  end

  // Stimulus: reset, run well into the second frame, reset mid-frame, restart.
  initial begin
    #1 rst = 1'b1;
    //     rst cyc    dut h    v  blank hs vs pen fs
    pv(1, 0,     0, 0,   0, 0, 1, 1, 0, 0);
    pv(1, 0,     1, 0,   0, 0, 0, 0, 1, 0);
    pv(0, 0,     0, 0,   0, 0, 1, 1, 0, 0);
    pv(0, 0,     1, 0,   0, 0, 0, 0, 1, 0);
    pv(0, 1,     1, 1,   0, 0, 0, 0, 1, 0);
    pv(0, 2,     0, 0,   0, 0, 1, 1, 0, 0);
    pv(0, 3,     0, 0,   0, 0, 1, 1, 1, 0);
    pv(0, 4,     0, 1,   0, 0, 1, 1, 0, 0);
    pv(0, 7,     0, 1,   0, 0, 1, 1, 1, 0);
    pv(0, 639,   1, 639, 0, 0, 0, 0, 1, 0);
    pv(0, 640,   1, 640, 0, 1, 0, 0, 1, 0);
    pv(0, 655,   1, 655, 0, 1, 0, 0, 1, 0);
    pv(0, 656,   1, 656, 0, 1, 1, 0, 1, 0);
    pv(0, 751,   1, 751, 0, 1, 1, 0, 1, 0);
    pv(0, 752,   1, 752, 0, 1, 0, 0, 1, 0);
    pv(0, 799,   1, 799, 0, 1, 0, 0, 1, 0);
    pv(0, 800,   1, 0,   1, 0, 0, 0, 1, 0);
    pv(0, 2559,  0, 639, 0, 0, 1, 1, 1, 0);
    pv(0, 2560,  0, 640, 0, 1, 1, 1, 0, 0);
    pv(0, 2623,  0, 655, 0, 1, 1, 1, 1, 0);
    pv(0, 2624,  0, 656, 0, 1, 0, 1, 0, 0);
    pv(0, 3007,  0, 751, 0, 1, 0, 1, 1, 0);
    pv(0, 3008,  0, 752, 0, 1, 1, 1, 0, 0);
    pv(0, 3199,  0, 799, 0, 1, 1, 1, 1, 0);
    pv(0, 3200,  0, 0,   1, 0, 1, 1, 0, 0);
    pv(0, 4000,  1, 0,   5, 1, 0, 1, 1, 0);
    pv(0, 5599,  1, 799, 6, 1, 0, 1, 1, 0);
    pv(0, 5600,  1, 0,   7, 1, 0, 0, 1, 0);
    pv(0, 6399,  1, 799, 7, 1, 0, 0, 1, 0);
    pv(0, 6400,  1, 0,   0, 0, 0, 0, 1, 1);
    pv(0, 6401,  1, 1,   0, 0, 0, 0, 1, 0);
    pv(0, 12799, 0, 799, 3, 1, 1, 1, 1, 0);
    pv(0, 12800, 0, 0,   4, 1, 1, 1, 0, 0);
    pv(0, 14400, 0, 400, 4, 1, 1, 1, 0, 0);
    pv(0, 15999, 0, 799, 4, 1, 1, 1, 1, 0);
    pv(0, 16000, 0, 0,   5, 1, 1, 0, 0, 0);
    pv(0, 22399, 0, 799, 6, 1, 1, 0, 1, 0);
    pv(0, 22400, 0, 0,   7, 1, 1, 1, 0, 0);
    pv(0, 25599, 0, 799, 7, 1, 1, 1, 1, 0);
    pv(0, 25600, 0, 0,   0, 0, 1, 1, 0, 1);
    pv(0, 25601, 0, 0,   0, 0, 1, 1, 0, 0);
    pv(0, 47600, 0, 700, 6, 1, 0, 0, 0, 0);
    pv(0, 47600, 1, 400, 3, 0, 0, 0, 1, 0);

    pm(0, 0, 384);   pm(0, 0, 384);
    pm(0, 1, 6400);
    pm(0, 2, 1);
    pm(0, 3, 25600);
    pm(1, 0, 96);    pm(1, 0, 96);
    pm(1, 1, 1600);  pm(1, 1, 1600);
    pm(1, 2, 1);     pm(1, 2, 1);
    pm(1, 3, 6400);  pm(1, 3, 6400);  pm(1, 3, 6400);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset lands mid-cycle while dut 0 sits at (700,6) with both syncs active;
    // the monitor checks it before the next rising edge.
    repeat (47601) @(posedge clk);
    #1;
    pv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    pv(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    rst = 1'b1;

    pv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    pv(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    pv(0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
    pv(0, 3, 0, 0, 0, 0, 1, 1, 1, 0);
    pv(0, 4, 0, 1, 0, 0, 1, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;

    chk_int("pending_vectors", vq.size(), 0);
    chk_int("pending_measurements", mq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
